// File: rtl/stack_core_param_pkg.sv
// Shared types for the parametrised stack-machine core: opcodes, FSM states,
// fault codes and the per-opcode operand requirement.
package stack_core_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_NOT  = 3'd3,
    OP_PUSH = 3'd4,
    OP_POP  = 3'd5,
    OP_JMP  = 3'd6,
    OP_JZ   = 3'd7
  } opcode_e;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_POP_A  = 4'd2,
    S_POP_B  = 4'd3,
    S_EXEC   = 4'd4,
    S_MEM_RD = 4'd5,
    S_PUSH_W = 4'd6,
    S_MEM_WR = 4'd7,
    S_FAULT  = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE      = 2'b00,
    FC_UNDERFLOW = 2'b01,
    FC_OVERFLOW  = 2'b10
  } fault_e;

  function automatic logic [1:0] need_operands(input opcode_e op);
    case (op)
      OP_ADD, OP_SUB, OP_AND: return 2'd2;
      OP_NOT, OP_POP, OP_JZ:  return 2'd1;
      default:                return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/stack_core_param_if.sv
// Request/acknowledge port to the unified instruction/data memory.
// The core drives the master side; the memory answers on the slave side.
interface stack_core_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/stack_core_param_lifo.sv
// Register-array LIFO with an occupancy count; reads 0 when empty and
// silently ignores push-on-full and pop-on-empty.
module stack_lifo #(
  parameter  int DATA_W      = 8,
  parameter  int STACK_DEPTH = 8,
  localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1),
  localparam int IDX_W       = $clog2(STACK_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [DATA_W-1:0]  din,
  output logic [DATA_W-1:0]  tos,
  output logic [DEPTH_W-1:0] depth
);
  logic [DATA_W-1:0]  entry_r [STACK_DEPTH];
  logic [DEPTH_W-1:0] count_r;
  logic [IDX_W-1:0]   wr_idx_s;
  logic [IDX_W-1:0]   top_idx_s;
  logic               full_s;
  logic               empty_s;

  assign full_s    = (count_r == DEPTH_W'(STACK_DEPTH));
  assign empty_s   = (count_r == DEPTH_W'(0));
  assign wr_idx_s  = IDX_W'(count_r);
  assign top_idx_s = IDX_W'(count_r - DEPTH_W'(1));

  // Entry storage and occupancy count
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (push && !full_s) begin
      entry_r[wr_idx_s] <= din;
      count_r           <= count_r + DEPTH_W'(1);
    end else if (pop && !empty_s) begin
      count_r <= count_r - DEPTH_W'(1);
    end
  end

  assign tos   = empty_s ? '0 : entry_r[top_idx_s];
  assign depth = count_r;
endmodule

// File: rtl/stack_core_param.sv
// Multicycle stack-machine core: PC/IR/MDR/A/B, controller FSM and ALU,
// with a sticky FAULT state entered on stack underflow or overflow.
module stack_core_param
  import stack_core_pkg::*;
#(
  parameter  int DATA_W      = 8,
  parameter  int ADDR_W      = 5,
  parameter  int STACK_DEPTH = 8,
  localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  stack_core_param_if.master  mem,
  output logic [DATA_W-1:0]   tos,
  output logic [DEPTH_W-1:0]  depth,
  output logic [2:0]          opcode,
  output logic                fault,
  output logic [1:0]          fault_code
);
  state_e            state_r, next_state_s;
  fault_e            fault_code_r;
  logic              fault_r;
  logic [ADDR_W-1:0] pc_r;
  logic [DATA_W-1:0] ir_r, mdr_r, a_r, b_r;
  logic [DATA_W-1:0] alu_s, push_data_s;
  logic              push_s, pop_s, underflow_s, overflow_s;
  opcode_e           op_s;
  logic [ADDR_W-1:0] ir_addr_s;

  assign op_s        = opcode_e'(ir_r[DATA_W-1 -: 3]);
  assign ir_addr_s   = ir_r[ADDR_W-1:0];
  assign underflow_s = (depth < DEPTH_W'(need_operands(op_s)));
  assign overflow_s  = (op_s == OP_PUSH) && (depth == DEPTH_W'(STACK_DEPTH));

  stack_lifo #(.DATA_W(DATA_W), .STACK_DEPTH(STACK_DEPTH)) u_lifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (push_data_s),
    .tos   (tos),
    .depth (depth)
  );

  // ALU: A is the former top, B the entry beneath it
  always_comb begin
    case (op_s)
      OP_ADD:  alu_s = b_r + a_r;
      OP_SUB:  alu_s = b_r - a_r;
      OP_AND:  alu_s = b_r & a_r;
      OP_NOT:  alu_s = ~a_r;
      default: alu_s = '0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= S_FETCH;
    else     state_r <= next_state_s;
  end

  // FSM next-state logic; faults are decided in DECODE before any stack change
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_FETCH:  next_state_s = mem.mem_ack ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (underflow_s || overflow_s) begin
          next_state_s = S_FAULT;
        end else begin
          case (op_s)
            OP_ADD, OP_SUB, OP_AND, OP_NOT, OP_JZ: next_state_s = S_POP_A;
            OP_PUSH: next_state_s = S_MEM_RD;
            OP_POP:  next_state_s = S_MEM_WR;
            OP_JMP:  next_state_s = S_FETCH;
            default: next_state_s = S_FAULT;
          endcase
        end
      end
      S_POP_A: begin
        case (op_s)
          OP_ADD, OP_SUB, OP_AND: next_state_s = S_POP_B;
          OP_NOT:  next_state_s = S_EXEC;
          default: next_state_s = S_FETCH;
        endcase
      end
      S_POP_B:  next_state_s = S_EXEC;
      S_EXEC:   next_state_s = S_FETCH;
      S_MEM_RD: next_state_s = mem.mem_ack ? S_PUSH_W : S_MEM_RD;
      S_PUSH_W: next_state_s = S_FETCH;
      S_MEM_WR: next_state_s = mem.mem_ack ? S_FETCH : S_MEM_WR;
      S_FAULT:  next_state_s = S_FAULT;
      default:  next_state_s = S_FAULT;
    endcase
  end

  // FSM outputs: memory request and stack control, held stable until ack
  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = pc_r;
    mem.mem_wdata = tos;
    push_s        = 1'b0;
    pop_s         = 1'b0;
    push_data_s   = alu_s;
    case (state_r)
      S_FETCH:  mem.mem_req = !rst;
      S_MEM_RD: begin
        mem.mem_req  = !rst;
        mem.mem_addr = ir_addr_s;
      end
      S_MEM_WR: begin
        mem.mem_req  = !rst;
        mem.mem_we   = 1'b1;
        mem.mem_addr = ir_addr_s;
        pop_s        = mem.mem_ack;
      end
      S_POP_A, S_POP_B: pop_s = 1'b1;
      S_EXEC:   push_s = 1'b1;
      S_PUSH_W: begin
        push_s      = 1'b1;
        push_data_s = mdr_r;
      end
      default: push_s = 1'b0;
    endcase
  end

  // Architectural registers and sticky fault capture
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r         <= '0;
      ir_r         <= '0;
      mdr_r        <= '0;
      a_r          <= '0;
      b_r          <= '0;
      fault_r      <= 1'b0;
      fault_code_r <= FC_NONE;
    end else begin
      case (state_r)
        S_FETCH: if (mem.mem_ack) begin
          ir_r <= mem.mem_rdata;
          pc_r <= pc_r + ADDR_W'(1);
        end
        S_DECODE: begin
          if (underflow_s) begin
            fault_r      <= 1'b1;
            fault_code_r <= FC_UNDERFLOW;
          end else if (overflow_s) begin
            fault_r      <= 1'b1;
            fault_code_r <= FC_OVERFLOW;
          end else if (op_s == OP_JMP) begin
            pc_r <= ir_addr_s;
          end
        end
        S_POP_A: begin
          a_r <= tos;
          if ((op_s == OP_JZ) && (tos == '0)) pc_r <= ir_addr_s;
        end
        S_POP_B:  b_r <= tos;
        S_MEM_RD: if (mem.mem_ack) mdr_r <= mem.mem_rdata;
        default:  ;
      endcase
    end
  end

  assign opcode     = ir_r[DATA_W-1 -: 3];
  assign fault      = fault_r;
  assign fault_code = fault_code_r;
endmodule

// File: tb/tb_stack_core_param.sv
// Directed bench for stack_core_param: three parameterisations share one
// memory model with configurable ack latency; only the selected DUT runs.
module tb_stack_core_param;
  localparam logic [2:0] T_ADD = 3'd0, T_SUB = 3'd1, T_NOT = 3'd3, T_PUSH = 3'd4;
  localparam logic [2:0] T_POP = 3'd5, T_JMP = 3'd6, T_JZ = 3'd7;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] sel;
  int lat;
  int n_cmp = 0;
  int n_err = 0;

  logic        clr_en, ld_en;
  logic [7:0]  ld_addr;
  logic [15:0] ld_data;
  logic [15:0] tmem [256];
  int          wait_cnt;
  logic [7:0]  last_rd;

  logic        m_req, m_we, m_ack;
  logic [7:0]  m_addr;
  logic [15:0] m_wdata, m_rdata;
  logic [15:0] o_tos;
  logic [4:0]  o_depth;
  logic [2:0]  o_op;
  logic        o_fault;
  logic [1:0]  o_code;

  logic rst0, rst1, rst2;
  logic [7:0]  tos0, tos1;
  logic [15:0] tos2;
  logic [3:0]  depth0;
  logic [2:0]  depth1;
  logic [4:0]  depth2;
  logic [2:0]  op0, op1, op2;
  logic        fault0, fault1, fault2;
  logic [1:0]  code0, code1, code2;

  always #5 clk = ~clk;

  assign rst0 = rst | (sel != 2'd0);
  assign rst1 = rst | (sel != 2'd1);
  assign rst2 = rst | (sel != 2'd2);

  stack_core_param_if #(.DATA_W(8),  .ADDR_W(5)) if0 ();
  stack_core_param_if #(.DATA_W(8),  .ADDR_W(5)) if1 ();
  stack_core_param_if #(.DATA_W(16), .ADDR_W(8)) if2 ();

  stack_core_param #(.DATA_W(8), .ADDR_W(5), .STACK_DEPTH(8)) dut0 (
    .clk(clk), .rst(rst0), .mem(if0), .tos(tos0), .depth(depth0),
    .opcode(op0), .fault(fault0), .fault_code(code0));
  stack_core_param #(.DATA_W(8), .ADDR_W(5), .STACK_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst1), .mem(if1), .tos(tos1), .depth(depth1),
    .opcode(op1), .fault(fault1), .fault_code(code1));
  stack_core_param #(.DATA_W(16), .ADDR_W(8), .STACK_DEPTH(16)) dut2 (
    .clk(clk), .rst(rst2), .mem(if2), .tos(tos2), .depth(depth2),
    .opcode(op2), .fault(fault2), .fault_code(code2));

  assign m_ack   = m_req && (wait_cnt == lat);
  assign m_rdata = tmem[m_addr];
  assign if0.mem_ack = (sel == 2'd0) && m_ack;
  assign if1.mem_ack = (sel == 2'd1) && m_ack;
  assign if2.mem_ack = (sel == 2'd2) && m_ack;
  assign if0.mem_rdata = m_rdata[7:0];
  assign if1.mem_rdata = m_rdata[7:0];
  assign if2.mem_rdata = m_rdata;

  // Route the selected DUT onto the shared memory model and observation bus
  always_comb begin
    m_req = 1'b0; m_we = 1'b0; m_addr = 8'h00; m_wdata = 16'h0000;
    o_tos = 16'h0000; o_depth = 5'd0; o_op = 3'd0; o_fault = 1'b0; o_code = 2'd0;
    case (sel)
      2'd0: begin
        m_req = if0.mem_req; m_we = if0.mem_we;
        m_addr = {3'b000, if0.mem_addr}; m_wdata = {8'h00, if0.mem_wdata};
        o_tos = {8'h00, tos0}; o_depth = {1'b0, depth0}; o_op = op0; o_fault = fault0; o_code = code0;
      end
      2'd1: begin
        m_req = if1.mem_req; m_we = if1.mem_we;
        m_addr = {3'b000, if1.mem_addr}; m_wdata = {8'h00, if1.mem_wdata};
        o_tos = {8'h00, tos1}; o_depth = {2'b00, depth1}; o_op = op1; o_fault = fault1; o_code = code1;
      end
      default: begin
        m_req = if2.mem_req; m_we = if2.mem_we;
        m_addr = if2.mem_addr; m_wdata = if2.mem_wdata;
        o_tos = tos2; o_depth = depth2; o_op = op2; o_fault = fault2; o_code = code2;
      end
    endcase
  end

  // Memory model: load port, stores, read tracking and wait-cycle counter
  always @(posedge clk) begin
    if (clr_en) begin
      for (int i = 0; i < 256; i++) tmem[i] <= 16'h0000;
    end else if (ld_en) begin
      tmem[ld_addr] <= ld_data;
    end else if (m_req && m_ack) begin
      if (m_we) tmem[m_addr] <= m_wdata;
      else      last_rd <= m_addr;
      wait_cnt <= 0;
    end else if (m_req) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] i8(input logic [2:0] op, input logic [4:0] a);
    return {8'h00, op, a};
  endfunction

  function automatic logic [15:0] i16(input logic [2:0] op, input logic [7:0] a);
    return {op, 5'b00000, a};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic poke(input int a, input logic [15:0] d);
    ld_addr = 8'(a); ld_data = d; ld_en = 1'b1;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic begin_test(input logic [1:0] k, input int l);
    rst = 1'b1; sel = k; lat = l;
    @(negedge clk);
    clr_en = 1'b1;
    @(negedge clk);
    clr_en = 1'b0;
  endtask

  task automatic load_arith8();
    poke(0, i8(T_PUSH, 5'd10)); poke(1, i8(T_PUSH, 5'd11)); poke(2, i8(T_ADD, 5'd0));
    poke(3, i8(T_POP, 5'd12));  poke(4, i8(T_JMP, 5'd4));
    poke(10, 16'd7); poke(11, 16'd250);
  endtask

  task automatic load_jz(input logic [15:0] cond);
    poke(0, i8(T_PUSH, 5'd10)); poke(1, i8(T_JZ, 5'd5)); poke(2, i8(T_PUSH, 5'd11));
    poke(3, i8(T_JMP, 5'd3));   poke(5, i8(T_PUSH, 5'd12)); poke(6, i8(T_JMP, 5'd6));
    poke(10, cond); poke(11, 16'h0055); poke(12, 16'h00AA);
  endtask

  initial begin
    logic req_seen;
    rst = 1'b1; sel = 2'd0; lat = 0; clr_en = 1'b0; ld_en = 1'b0;
    ld_addr = 8'h00; ld_data = 16'h0000;
    @(negedge clk);

    // Arithmetic, zero wait: cycle-exact progress
    begin_test(2'd0, 0);
    check_eq("rst_tos", 32'(o_tos), 32'd0);
    check_eq("rst_depth", 32'(o_depth), 32'd0);
    check_eq("rst_req", 32'(m_req), 32'd0);
    load_arith8();
    rst = 1'b0;
    step(4);  check_eq("ar_push1_depth", 32'(o_depth), 32'd1); check_eq("ar_push1_tos", 32'(o_tos), 32'd7);
    step(4);  check_eq("ar_push2_tos", 32'(o_tos), 32'd250);
    step(5);  check_eq("ar_add_tos", 32'(o_tos), 32'd1);      check_eq("ar_add_depth", 32'(o_depth), 32'd1);
    step(3);  check_eq("ar_pop_depth", 32'(o_depth), 32'd0);  check_eq("ar_mem12", 32'(tmem[12]), 32'd1);
    check_eq("ar_pop_opcode", 32'(o_op), 32'd5);
    step(20); check_eq("ar_loop_addr", 32'(m_addr), 32'd4);   check_eq("ar_loop_rd", 32'(last_rd), 32'd4);

    // Arithmetic, three wait cycles per access
    begin_test(2'd0, 3);
    load_arith8();
    rst = 1'b0;
    step(9);   check_eq("w3_push1_early", 32'(o_depth), 32'd0);
    step(1);   check_eq("w3_push1_done", 32'(o_depth), 32'd1);
    step(100); check_eq("w3_mem12", 32'(tmem[12]), 32'd1); check_eq("w3_depth", 32'(o_depth), 32'd0);

    // SUB operand order: 9 - 3
    begin_test(2'd0, 0);
    poke(0, i8(T_PUSH, 5'd10)); poke(1, i8(T_PUSH, 5'd11)); poke(2, i8(T_SUB, 5'd0));
    poke(3, i8(T_JMP, 5'd3)); poke(10, 16'd9); poke(11, 16'd3);
    rst = 1'b0;
    step(13); check_eq("sub_tos", 32'(o_tos), 32'd6); check_eq("sub_depth", 32'(o_depth), 32'd1);

    // NOT
    begin_test(2'd0, 0);
    poke(0, i8(T_PUSH, 5'd10)); poke(1, i8(T_NOT, 5'd0)); poke(2, i8(T_JMP, 5'd2)); poke(10, 16'h000F);
    rst = 1'b0;
    step(4); check_eq("not_before", 32'(o_tos), 32'h0F);
    step(4); check_eq("not_tos", 32'(o_tos), 32'hF0); check_eq("not_depth", 32'(o_depth), 32'd1);

    // JZ taken and not taken
    begin_test(2'd0, 0);
    load_jz(16'h0000);
    rst = 1'b0;
    step(7);  check_eq("jz_t_depth", 32'(o_depth), 32'd0); check_eq("jz_t_pc", 32'(m_addr), 32'd5);
    step(20); check_eq("jz_t_tos", 32'(o_tos), 32'hAA);    check_eq("jz_t_rd", 32'(last_rd), 32'd6);
    begin_test(2'd0, 0);
    load_jz(16'h0005);
    rst = 1'b0;
    step(7);  check_eq("jz_n_depth", 32'(o_depth), 32'd0); check_eq("jz_n_pc", 32'(m_addr), 32'd2);
    step(20); check_eq("jz_n_tos", 32'(o_tos), 32'h55);    check_eq("jz_n_rd", 32'(last_rd), 32'd3);

    // Underflow: ADD on an empty stack
    begin_test(2'd0, 0);
    rst = 1'b0;
    step(1); check_eq("uf_not_yet", 32'(o_fault), 32'd0);
    step(1); check_eq("uf_fault", 32'(o_fault), 32'd1); check_eq("uf_code", 32'(o_code), 32'd1);
    check_eq("uf_depth", 32'(o_depth), 32'd0);
    req_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      req_seen = req_seen | m_req;
    end
    check_eq("uf_req_quiet", 32'(req_seen), 32'd0);

    // Overflow with a four-entry stack, then reset recovery
    begin_test(2'd1, 0);
    for (int i = 0; i < 5; i++) begin
      poke(i, i8(T_PUSH, 5'(20 + i)));
      poke(20 + i, 16'(11 * (i + 1)));
    end
    rst = 1'b0;
    step(16); check_eq("of_full_depth", 32'(o_depth), 32'd4); check_eq("of_no_fault", 32'(o_fault), 32'd0);
    step(2);  check_eq("of_fault", 32'(o_fault), 32'd1);      check_eq("of_code", 32'(o_code), 32'd2);
    step(10); check_eq("of_depth", 32'(o_depth), 32'd4);      check_eq("of_tos", 32'(o_tos), 32'd44);
    check_eq("of_req", 32'(m_req), 32'd0);                    check_eq("of_opcode", 32'(o_op), 32'd4);
    rst = 1'b1;
    step(1);  check_eq("of_rst_tos", 32'(o_tos), 32'd0);      check_eq("of_rst_depth", 32'(o_depth), 32'd0);
    check_eq("of_rst_fault", 32'(o_fault), 32'd0);            check_eq("of_rst_code", 32'(o_code), 32'd0);
    check_eq("of_rst_opcode", 32'(o_op), 32'd0);

    // PC wrap from address 31 to 0
    begin_test(2'd0, 0);
    poke(0, i8(T_PUSH, 5'd10)); poke(1, i8(T_JZ, 5'd30)); poke(30, i8(T_PUSH, 5'd11));
    poke(31, i8(T_POP, 5'd12)); poke(10, 16'h0000); poke(11, 16'h003C);
    rst = 1'b0;
    step(14); check_eq("wrap_req", 32'(m_req), 32'd1); check_eq("wrap_pc", 32'(m_addr), 32'd0);
    check_eq("wrap_mem12", 32'(tmem[12]), 32'h3C);

    // Arithmetic on the 16-bit / 8-bit-address / 16-deep variant
    begin_test(2'd2, 0);
    poke(0, i16(T_PUSH, 8'd100)); poke(1, i16(T_PUSH, 8'd101)); poke(2, i16(T_ADD, 8'd0));
    poke(3, i16(T_POP, 8'd200));  poke(4, i16(T_JMP, 8'd4));
    poke(100, 16'd7); poke(101, 16'hFFFA);
    rst = 1'b0;
    step(8);  check_eq("w16_push2_tos", 32'(o_tos), 32'hFFFA); check_eq("w16_depth2", 32'(o_depth), 32'd2);
    step(5);  check_eq("w16_add_tos", 32'(o_tos), 32'd1);
    step(3);  check_eq("w16_mem200", 32'(tmem[200]), 32'd1);   check_eq("w16_depth0", 32'(o_depth), 32'd0);
    step(20); check_eq("w16_loop_addr", 32'(m_addr), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
